// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: shifts a host word through a chain of scan flops,
// issues single capture pulses and passes the functional cp through when idle.
module scan_chain_ctrl #(
    parameter int unsigned CHAIN_LEN = 32,
    parameter int unsigned CNT_W     = 6,
    parameter int unsigned GAP_CYC   = 0
) (
    input  logic                 sys_clk,
    input  logic                 cd,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CHAIN_LEN-1:0] cmd_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CHAIN_LEN-1:0] rsp_data,
    input  logic                 scan_so,
    input  logic                 func_cp,
    output logic                 scan_cp,
    output logic                 scan_te,
    output logic                 scan_ti
);

    typedef enum logic [2:0] {
        IDLE,
        CAPT,
        SETUP,
        SHIFT,
        GAP,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP        = 2'b00,
        OP_SHIFT      = 2'b01,
        OP_CAPTURE    = 2'b10,
        OP_CAPT_SHIFT = 2'b11
    } op_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [3:0]       GAP_LAST = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

    state_t               state,    state_nxt;
    op_t                  op,       op_nxt;
    logic [CHAIN_LEN-1:0] sh,       sh_nxt;
    logic [CNT_W-1:0]     cnt,      cnt_nxt;
    logic [3:0]           gap_cnt,  gap_cnt_nxt;
    logic                 cp_pulse, cp_pulse_nxt;
    logic                 te_nxt;
    logic                 ti_nxt;
    logic                 rsp_valid_nxt;
    logic [CHAIN_LEN-1:0] rsp_data_nxt;

    assign cmd_ready = (state == IDLE);
    assign scan_cp   = (state == IDLE) ? func_cp : cp_pulse;

    always_ff @(posedge sys_clk or negedge cd) begin
        if (!cd) begin
            state     <= IDLE;
            op        <= OP_NOP;
            sh        <= '0;
            cnt       <= '0;
            gap_cnt   <= '0;
            cp_pulse  <= 1'b0;
            scan_te   <= 1'b0;
            scan_ti   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nxt;
            op        <= op_nxt;
            sh        <= sh_nxt;
            cnt       <= cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            cp_pulse  <= cp_pulse_nxt;
            scan_te   <= te_nxt;
            scan_ti   <= ti_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
        end
    end

    // Registered pin values are computed for the state being entered, so
    // cp/te/ti are valid for the whole cycle that state occupies.
    always_comb begin
        state_nxt     = state;
        op_nxt        = op;
        sh_nxt        = sh;
        cnt_nxt       = cnt;
        gap_cnt_nxt   = gap_cnt;
        cp_pulse_nxt  = cp_pulse;
        te_nxt        = scan_te;
        ti_nxt        = scan_ti;
        rsp_valid_nxt = rsp_valid;
        rsp_data_nxt  = rsp_data;

        unique case (state)
            IDLE: begin
                cnt_nxt      = '0;
                gap_cnt_nxt  = '0;
                cp_pulse_nxt = 1'b0;
                te_nxt       = 1'b0;
                ti_nxt       = 1'b0;
                if (cmd_valid) begin
                    sh_nxt = cmd_data;
                    op_nxt = op_t'(cmd_op);
                    unique case (op_t'(cmd_op))
                        OP_NOP: state_nxt = DONE;
                        OP_SHIFT: begin
                            state_nxt = SETUP;
                            te_nxt    = 1'b1;
                            ti_nxt    = cmd_data[CHAIN_LEN-1];
                        end
                        default: begin
                            state_nxt    = CAPT;
                            cp_pulse_nxt = 1'b1;
                        end
                    endcase
                end
            end

            CAPT: begin
                cp_pulse_nxt = 1'b0;
                if (op == OP_CAPT_SHIFT) begin
                    state_nxt = SETUP;
                    te_nxt    = 1'b1;
                    ti_nxt    = sh[CHAIN_LEN-1];
                end else begin
                    state_nxt = DONE;
                end
            end

            SETUP: begin
                state_nxt    = SHIFT;
                cp_pulse_nxt = 1'b1;
            end

            SHIFT: begin
                // scan_so is the tail value before this pulse takes effect
                sh_nxt  = {sh[CHAIN_LEN-2:0], scan_so};
                cnt_nxt = cnt + 1'b1;
                ti_nxt  = sh[CHAIN_LEN-2];
                if (cnt == CNT_LAST) begin
                    state_nxt    = DONE;
                    cp_pulse_nxt = 1'b0;
                    te_nxt       = 1'b0;
                    ti_nxt       = 1'b0;
                end else if (GAP_CYC > 0) begin
                    state_nxt    = GAP;
                    cp_pulse_nxt = 1'b0;
                    gap_cnt_nxt  = '0;
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt    = SHIFT;
                    cp_pulse_nxt = 1'b1;
                end else begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                end
            end

            DONE: begin
                cp_pulse_nxt = 1'b0;
                te_nxt       = 1'b0;
                ti_nxt       = 1'b0;
                if (!rsp_valid) begin
                    rsp_valid_nxt = 1'b1;
                    if (op == OP_SHIFT || op == OP_CAPT_SHIFT)
                        rsp_data_nxt = sh;
                end else if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: two instances (no gap, 2-cycle gap) each driving
// a behavioural 32-flop scan chain; directed vectors plus reset/handshake sequences.
module tb_scan_chain_ctrl;

    logic        clk = 1'b0;
    logic        cd;
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic [1:0]  cmd_op    [2];
    logic [31:0] cmd_data  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data  [2];
    logic        func_cp   [2];
    logic        scan_cp   [2];
    logic        scan_te   [2];
    logic        scan_ti   [2];

    logic [31:0] chain  [2];
    logic [31:0] d      [2];
    logic [31:0] pl_val [2];
    logic        pl_req [2];
    logic        clr    [2];

    int cyc;
    int np    [2];
    int ones  [2];
    int tecyc [2];
    int last  [2];
    int smin  [2];
    int smax  [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    scan_chain_ctrl #(.CHAIN_LEN(32), .CNT_W(6), .GAP_CYC(0)) u_dut (
        .sys_clk(clk), .cd(cd),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
        .cmd_data(cmd_data[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_data(rsp_data[0]), .scan_so(chain[0][31]), .func_cp(func_cp[0]),
        .scan_cp(scan_cp[0]), .scan_te(scan_te[0]), .scan_ti(scan_ti[0])
    );

    scan_chain_ctrl #(.CHAIN_LEN(32), .CNT_W(6), .GAP_CYC(2)) u_gap (
        .sys_clk(clk), .cd(cd),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
        .cmd_data(cmd_data[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_data(rsp_data[1]), .scan_so(chain[1][31]), .func_cp(func_cp[1]),
        .scan_cp(scan_cp[1]), .scan_te(scan_te[1]), .scan_ti(scan_ti[1])
    );

    // Chain flops plus pulse/te monitors
    always @(posedge clk) begin
        int sp;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (pl_req[i])
                chain[i] <= pl_val[i];
            else if (scan_cp[i])
                chain[i] <= scan_te[i] ? {chain[i][30:0], scan_ti[i]} : d[i];
            if (clr[i]) begin
                np[i] = 0; ones[i] = 0; tecyc[i] = 0; smin[i] = 999; smax[i] = 0;
            end else begin
                if (scan_cp[i]) begin
                    if (np[i] > 0) begin
                        sp = cyc - last[i];
                        if (sp < smin[i]) smin[i] = sp;
                        if (sp > smax[i]) smax[i] = sp;
                    end
                    last[i] = cyc;
                    np[i]++;
                    if (scan_te[i]) ones[i]++;
                end
                if (scan_te[i]) tecyc[i]++;
            end
        end
    end

    typedef struct {
        int          dut;
        logic [1:0]  op;
        logic [31:0] data;
        logic [31:0] pl;
        logic [31:0] dv;
        logic [31:0] exp_rsp;
        logic [31:0] exp_chain;
        int          lat;
        int          np;
        int          ones;
        int          tecyc;
        int          smin;
        int          smax;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int i;
        int lat;
        i = v.dut;
        @(negedge clk);
        d[i] = v.dv; pl_val[i] = v.pl; pl_req[i] = 1'b1; clr[i] = 1'b1;
        @(negedge clk);
        pl_req[i] = 1'b0; clr[i] = 1'b0;
        chk({tag, " cmd_ready"}, 32'(cmd_ready[i]), 32'd1);
        cmd_valid[i] = 1'b1; cmd_op[i] = v.op; cmd_data[i] = v.data;
        @(posedge clk); #1;
        cmd_valid[i] = 1'b0;
        lat = 0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (rsp_valid[i]) begin
                lat = k;
                break;
            end
        end
        chk({tag, " latency"},   32'(lat),      32'(v.lat));
        chk({tag, " rsp_data"},  rsp_data[i],   v.exp_rsp);
        chk({tag, " chain"},     chain[i],      v.exp_chain);
        chk({tag, " pulses"},    32'(np[i]),    32'(v.np));
        chk({tag, " te_pulses"}, 32'(ones[i]),  32'(v.ones));
        chk({tag, " te_cycles"}, 32'(tecyc[i]), 32'(v.tecyc));
        chk({tag, " min_space"}, 32'((np[i] < 2) ? 0 : smin[i]), 32'(v.smin));
        chk({tag, " max_space"}, 32'(smax[i]),  32'(v.smax));
        // hold the response with func_cp high and a stray command pending
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            func_cp[i] = 1'b1; cmd_valid[i] = 1'b1; cmd_op[i] = 2'b01;
            #1;
            chk({tag, " hold scan_cp"},   32'(scan_cp[i]),   32'd0);
            chk({tag, " hold rsp_valid"}, 32'(rsp_valid[i]), 32'd1);
            chk({tag, " hold rsp_data"},  rsp_data[i],       v.exp_rsp);
            chk({tag, " hold cmd_ready"}, 32'(cmd_ready[i]), 32'd0);
        end
        @(negedge clk);
        func_cp[i] = 1'b0; cmd_valid[i] = 1'b0; rsp_ready[i] = 1'b1;
        @(posedge clk); #1;
        chk({tag, " rsp_valid drop"}, 32'(rsp_valid[i]), 32'd0);
        chk({tag, " ready again"},    32'(cmd_ready[i]), 32'd1);
        rsp_ready[i] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        //        dut op     data          preload       d             exp_rsp       exp_chain     lat np ones te sm sx
        vecs[0] = '{0, 2'b01, 32'hCAFEF00D, 32'h12345678, 32'h00000000, 32'h12345678, 32'hCAFEF00D, 34, 32, 32, 33, 1, 1};
        vecs[1] = '{0, 2'b10, 32'h5555AAAA, 32'h00000000, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5,  2,  1,  0,  0, 0, 0};
        vecs[2] = '{0, 2'b11, 32'h00000000, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h00000000, 35, 33, 32, 33, 1, 2};
        vecs[3] = '{0, 2'b00, 32'h11111111, 32'hDEADBEEF, 32'h00000000, 32'h0F0F0F0F, 32'hDEADBEEF,  1,  0,  0,  0, 0, 0};
        vecs[4] = '{0, 2'b01, 32'hFFFFFFFF, 32'h80000001, 32'h00000000, 32'h80000001, 32'hFFFFFFFF, 34, 32, 32, 33, 1, 1};
        vecs[5] = '{0, 2'b01, 32'h00000001, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFE, 32'h00000001, 34, 32, 32, 33, 1, 1};
        vecs[6] = '{1, 2'b01, 32'h13579BDF, 32'h2468ACE0, 32'h00000000, 32'h2468ACE0, 32'h13579BDF, 96, 32, 32, 95, 3, 3};

        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0; cmd_op[i] = 2'b00; cmd_data[i] = '0;
            rsp_ready[i] = 1'b0; func_cp[i] = 1'b0; d[i] = '0;
            pl_val[i] = '0; pl_req[i] = 1'b0; clr[i] = 1'b1;
        end
        cd = 1'b1;
        #1 cd = 1'b0;
        #11;
        chk("reset scan_cp",   32'(scan_cp[0]),   32'd0);
        chk("reset scan_te",   32'(scan_te[0]),   32'd0);
        chk("reset scan_ti",   32'(scan_ti[0]),   32'd0);
        chk("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("reset rsp_data",  rsp_data[0],       32'd0);
        @(negedge clk);
        cd = 1'b1;
        #1;
        chk("post-reset cmd_ready", 32'(cmd_ready[0]), 32'd1);

        // functional cp passes straight through while idle
        @(negedge clk);
        func_cp[0] = 1'b1; #1;
        chk("idle func_cp high", 32'(scan_cp[0]), 32'd1);
        func_cp[0] = 1'b0; #1;
        chk("idle func_cp low",  32'(scan_cp[0]), 32'd0);

        for (int r = 0; r < 7; r++)
            run_vec(vecs[r], $sformatf("vec%0d", r));

        // reset in the middle of a shift
        @(negedge clk);
        cmd_valid[0] = 1'b1; cmd_op[0] = 2'b01; cmd_data[0] = 32'hA5A50F0F;
        @(posedge clk); #1;
        cmd_valid[0] = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("mid-shift scan_te", 32'(scan_te[0]), 32'd1);
        chk("mid-shift scan_cp", 32'(scan_cp[0]), 32'd1);
        cd = 1'b0;
        #1;
        chk("abort scan_cp",   32'(scan_cp[0]),   32'd0);
        chk("abort scan_te",   32'(scan_te[0]),   32'd0);
        chk("abort scan_ti",   32'(scan_ti[0]),   32'd0);
        chk("abort rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("abort rsp_data",  rsp_data[0],       32'd0);
        @(negedge clk);
        cd = 1'b1;
        #1;
        chk("abort cmd_ready", 32'(cmd_ready[0]), 32'd1);

        rv = '{0, 2'b00, 32'h00000000, 32'h0BADF00D, 32'h00000000, 32'h00000000, 32'h0BADF00D, 1, 0, 0, 0, 0, 0};
        run_vec(rv, "nop_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
